// File: rtl/mem_2_axi4_lite.sv
// mem_2_axi4_lite: AXI4-Lite initiator that turns single-word client
// read/write commands into AXI4-Lite master transactions, one outstanding
// at a time, with exactly one client response per command.
// Optional feature macro: MEM2AXI_ERRCNT_EN adds a saturating 16-bit
// err_count of SLVERR/DECERR responses captured from B or R.
module mem_2_axi4_lite #(
   parameter int ALEN     = 32,
   parameter int DLEN     = 32,
   parameter int SLEN     = DLEN / 8,
   parameter int MEM_ALEN = 10
) (
   input  logic                clk,
   input  logic                rstn,
   // client command
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_we,
   input  logic [MEM_ALEN-1:0] cmd_addr,
   input  logic [DLEN-1:0]     cmd_wdata,
   input  logic [SLEN-1:0]     cmd_wstrb,
   // client response
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_we,
   output logic [DLEN-1:0]     rsp_rdata,
   output logic [1:0]          rsp_resp,
   // AXI AW
   output logic                awvalid,
   input  logic                awready,
   output logic [ALEN-1:0]     awaddr,
   output logic [2:0]          awprot,
   // AXI W
   output logic                wvalid,
   input  logic                wready,
   output logic [DLEN-1:0]     wdata,
   output logic [SLEN-1:0]     wstrb,
   // AXI B
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   // AXI AR
   output logic                arvalid,
   input  logic                arready,
   output logic [ALEN-1:0]     araddr,
   output logic [2:0]          arprot,
   // AXI R
   input  logic                rvalid,
   output logic                rready,
   input  logic [DLEN-1:0]     rdata,
   input  logic [1:0]          rresp
`ifdef MEM2AXI_ERRCNT_EN
   ,
   output logic [15:0]         err_count
`endif
);

   // Handshake rule on every channel: a transfer happens on the rising clk
   // edge where valid & ready are both 1. Our valids are registered, never
   // depend on the matching ready, and once raised stay up with stable
   // payload until their handshake edge; readies are only raised in the
   // state waiting for that channel.

   localparam int OFF = $clog2(SLEN);

   if ((ALEN < MEM_ALEN + OFF) || (DLEN % 8 != 0)) begin : g_bad_params
      $error("mem_2_axi4_lite: need DLEN multiple of 8 and ALEN >= MEM_ALEN + clog2(SLEN)");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR    = 3'd1,
      WRESP = 3'd2,
      RADDR = 3'd3,
      RDATA = 3'd4,
      RSP   = 3'd5
   } state_t;

   state_t          state;
   logic [ALEN-1:0] byte_addr;
   logic            aw_fin;
   logic            w_fin;

   // word address -> byte address (low OFF bits zero)
   assign byte_addr = ALEN'(cmd_addr) << OFF;
   assign cmd_ready = (state == IDLE);
   assign awprot    = 3'b000;
   assign arprot    = 3'b000;

   // an AW/W leg is finished once its valid has dropped or handshakes now
   assign aw_fin = ~awvalid | awready;
   assign w_fin  = ~wvalid | wready;

   // transaction FSM with all AXI and response outputs registered
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         arvalid   <= 1'b0;
         bready    <= 1'b0;
         rready    <= 1'b0;
         awaddr    <= '0;
         araddr    <= '0;
         wdata     <= '0;
         wstrb     <= '0;
         rsp_valid <= 1'b0;
         rsp_we    <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_we) begin
                     state   <= WR;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     awaddr  <= byte_addr;
                     wdata   <= cmd_wdata;
                     wstrb   <= cmd_wstrb;
                  end else begin
                     state   <= RADDR;
                     arvalid <= 1'b1;
                     araddr  <= byte_addr;
                  end
               end
            end
            WR: begin
               // AW and W complete independently; leave when both are done
               if (awready) awvalid <= 1'b0;
               if (wready)  wvalid  <= 1'b0;
               if (aw_fin && w_fin) begin
                  state  <= WRESP;
                  bready <= 1'b1;
               end
            end
            WRESP: begin
               if (bvalid) begin
                  bready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_we    <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_resp  <= bresp;
                  state     <= RSP;
               end
            end
            RADDR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RDATA;
               end
            end
            RDATA: begin
               if (rvalid) begin
                  rready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_we    <= 1'b0;
                  rsp_rdata <= rdata;
                  rsp_resp  <= rresp;
                  state     <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM2AXI_ERRCNT_EN
   logic err_hit;

   // error response (resp[1] set) captured on B or R this cycle
   assign err_hit = ((state == WRESP) && bvalid && bresp[1]) ||
                    ((state == RDATA) && rvalid && rresp[1]);

   // saturating error counter
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_count <= 16'h0000;
      end else if (err_hit && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule
